// File: rtl/qacc_if.sv
// Valid/ready data-transfer interface (dti) used on both sides of the queue reducer.
interface dti #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
    modport master   (output valid, output data, input ready);
    modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/qacc.sv
// Queue reducer: sums an eot-terminated stream and emits {count, sum} per queue.
// Define QACC_SAT_EN to make the sum and the count saturate instead of wrapping.
module qacc #(
    parameter int W_DATA = 16,
    parameter int W_ACC  = 32,
    parameter int W_CNT  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    dti.consumer  din,
    dti.producer  dout
);
    localparam logic [W_ACC-1:0] LO_MASK = W_ACC'({W_DATA{1'b1}});
`ifdef QACC_SAT_EN
    localparam logic [W_ACC-1:0] ACC_MAX_S = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic [W_ACC-1:0] ACC_MIN_S = ~ACC_MAX_S;

    function automatic logic [W_ACC-1:0] acc_add(input logic [W_ACC-1:0] a,
                                                 input logic [W_ACC-1:0] b);
        logic [W_ACC:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SIGNED) begin
            // Overflow only when both operands share a sign the result lacks.
            if ((a[W_ACC-1] == b[W_ACC-1]) && (s[W_ACC-1] != a[W_ACC-1]))
                return a[W_ACC-1] ? ACC_MIN_S : ACC_MAX_S;
        end else if (s[W_ACC]) begin
            return '1;
        end
        return s[W_ACC-1:0];
    endfunction

    function automatic logic [W_CNT-1:0] cnt_inc(input logic [W_CNT-1:0] a);
        return (&a) ? a : a + W_CNT'(1);
    endfunction
`else
    function automatic logic [W_ACC-1:0] acc_add(input logic [W_ACC-1:0] a,
                                                 input logic [W_ACC-1:0] b);
        return a + b;
    endfunction

    function automatic logic [W_CNT-1:0] cnt_inc(input logic [W_CNT-1:0] a);
        return a + W_CNT'(1);
    endfunction
`endif

    logic [W_ACC-1:0]       acc_q, acc_d;
    logic [W_CNT-1:0]       cnt_q, cnt_d;
    logic                   started_q, started_d;
    logic                   out_valid_q, out_valid_d;
    logic [W_CNT+W_ACC-1:0] out_data_q, out_data_d;

    logic                   eot;
    logic [W_DATA-1:0]      elem;
    logic [W_ACC-1:0]       ext;
    logic [W_ACC-1:0]       acc_next;
    logic [W_CNT-1:0]       cnt_next;
    logic                   din_ready;
    logic                   din_hs;

    assign eot       = din.data[W_DATA];
    assign elem      = din.data[W_DATA-1:0];
    assign din_ready = ~out_valid_q | dout.ready;
    assign din_hs    = din.valid & din_ready;

    assign din.ready  = din_ready;
    assign dout.valid = out_valid_q;
    assign dout.data  = out_data_q;

    always_comb begin
        ext = W_ACC'(elem);
        if (SIGNED && elem[W_DATA-1])
            ext = ext | ~LO_MASK;
        // A fresh queue starts from zero, so the first element can never overflow.
        acc_next = acc_add(started_q ? acc_q : '0, ext);
        cnt_next = cnt_inc(started_q ? cnt_q : '0);
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        started_d   = started_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_valid_q && dout.ready)
            out_valid_d = 1'b0;
        if (din_hs) begin
            if (eot) begin
                out_valid_d = 1'b1;
                out_data_d  = {cnt_next, acc_next};
                acc_d       = '0;
                cnt_d       = '0;
                started_d   = 1'b0;
            end else begin
                acc_d       = acc_next;
                cnt_d       = cnt_next;
                started_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            started_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            started_q   <= started_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_qacc.sv
// Directed testbench for qacc: four parameterisations driven by per-scenario tasks.
module tb_qacc;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dti #(.W(17)) if0_in  ();
    dti #(.W(48)) if0_out ();
    dti #(.W(9))  if1_in  ();
    dti #(.W(48)) if1_out ();
    dti #(.W(9))  if2_in  ();
    dti #(.W(48)) if2_out ();
    dti #(.W(9))  if3_in  ();
    dti #(.W(16)) if3_out ();

    qacc u_def (.clk(clk), .rst(rst), .din(if0_in), .dout(if0_out));
    qacc #(.W_DATA(8), .W_ACC(32), .W_CNT(16), .SIGNED(1'b1))
        u_s8 (.clk(clk), .rst(rst), .din(if1_in), .dout(if1_out));
    qacc #(.W_DATA(8), .W_ACC(32), .W_CNT(16), .SIGNED(1'b0))
        u_u8 (.clk(clk), .rst(rst), .din(if2_in), .dout(if2_out));
    qacc #(.W_DATA(8), .W_ACC(8), .W_CNT(8), .SIGNED(1'b0))
        u_w8 (.clk(clk), .rst(rst), .din(if3_in), .dout(if3_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        checks++;
        if (if0_out.valid !== 1'b0 || if0_in.ready !== 1'b1 || if0_out.data !== 48'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h, want valid=0 ready=1 data=0",
                     if0_out.valid, if0_in.ready, if0_out.data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [16:0] vec [3];
        vec[0] = {1'b0, 16'd3};
        vec[1] = {1'b0, 16'd4};
        vec[2] = {1'b1, 16'd5};
        if0_out.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if0_in.valid = 1'b1;
            if0_in.data  = vec[i];
            checks++;
            if (if0_in.ready !== 1'b1 || if0_out.valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: ready=%b valid=%b, want ready=1 valid=0",
                         i, if0_in.ready, if0_out.valid);
            end
        end
        @(negedge clk);
        if0_in.valid = 1'b0;
        checks++;
        if (if0_out.valid !== 1'b1 || if0_out.data !== {16'd3, 32'd12}) begin
            errors++;
            $display("FAIL basic_result: valid=%b data=%h, want valid=1 data=%h",
                     if0_out.valid, if0_out.data, {16'd3, 32'd12});
        end
        @(negedge clk);
        checks++;
        if (if0_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: valid=%b, want 0", if0_out.valid);
        end
    endtask

    task automatic test_back_to_back();
        if0_out.ready = 1'b1;
        @(negedge clk);
        if0_in.valid = 1'b1;
        if0_in.data  = {1'b1, 16'd7};
        @(negedge clk);
        if0_in.data  = {1'b1, 16'd9};
        checks++;
        if (if0_out.valid !== 1'b1 || if0_out.data !== {16'd1, 32'd7} || if0_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b data=%h ready=%b, want valid=1 data=%h ready=1",
                     if0_out.valid, if0_out.data, if0_in.ready, {16'd1, 32'd7});
        end
        @(negedge clk);
        if0_in.valid = 1'b0;
        checks++;
        if (if0_out.valid !== 1'b1 || if0_out.data !== {16'd1, 32'd9}) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%h, want valid=1 data=%h",
                     if0_out.valid, if0_out.data, {16'd1, 32'd9});
        end
        @(negedge clk);
        checks++;
        if (if0_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, want 0", if0_out.valid);
        end
    endtask

    task automatic test_signed();
        if1_out.ready = 1'b1;
        if2_out.ready = 1'b1;
        @(negedge clk);
        if1_in.valid = 1'b1;
        if2_in.valid = 1'b1;
        if1_in.data  = {1'b0, 8'hFE};
        if2_in.data  = {1'b0, 8'hFE};
        @(negedge clk);
        if1_in.data  = {1'b1, 8'h05};
        if2_in.data  = {1'b1, 8'h05};
        @(negedge clk);
        if1_in.valid = 1'b0;
        if2_in.valid = 1'b0;
        checks++;
        if (if1_out.valid !== 1'b1 || if1_out.data !== {16'd2, 32'd3}) begin
            errors++;
            $display("FAIL signed_sum: valid=%b data=%h, want valid=1 data=%h",
                     if1_out.valid, if1_out.data, {16'd2, 32'd3});
        end
        checks++;
        if (if2_out.valid !== 1'b1 || if2_out.data !== {16'd2, 32'd259}) begin
            errors++;
            $display("FAIL unsigned_sum: valid=%b data=%h, want valid=1 data=%h",
                     if2_out.valid, if2_out.data, {16'd2, 32'd259});
        end
    endtask

    task automatic test_stall();
        if0_out.ready = 1'b0;
        @(negedge clk);
        if0_in.valid = 1'b1;
        if0_in.data  = {1'b1, 16'd6};
        @(negedge clk);
        if0_in.data  = {1'b0, 16'd8};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if0_in.ready !== 1'b0 || if0_out.valid !== 1'b1 || if0_out.data !== {16'd1, 32'd6}) begin
                errors++;
                $display("FAIL stall_cycle%0d: ready=%b valid=%b data=%h, want ready=0 valid=1 data=%h",
                         i, if0_in.ready, if0_out.valid, if0_out.data, {16'd1, 32'd6});
            end
            if (i < 3) @(negedge clk);
        end
        if0_out.ready = 1'b1;
        #1;
        checks++;
        if (if0_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ready=%b, want 1", if0_in.ready);
        end
        @(negedge clk);
        if0_in.data = {1'b1, 16'd2};
        checks++;
        if (if0_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: valid=%b, want 0", if0_out.valid);
        end
        @(negedge clk);
        if0_in.valid = 1'b0;
        checks++;
        if (if0_out.valid !== 1'b1 || if0_out.data !== {16'd2, 32'd10}) begin
            errors++;
            $display("FAIL stall_next_queue: valid=%b data=%h, want valid=1 data=%h",
                     if0_out.valid, if0_out.data, {16'd2, 32'd10});
        end
    endtask

    task automatic test_reset_midqueue();
        if0_out.ready = 1'b1;
        @(negedge clk);
        if0_in.valid = 1'b1;
        if0_in.data  = {1'b0, 16'd10};
        @(negedge clk);
        if0_in.data  = {1'b0, 16'd20};
        @(negedge clk);
        if0_in.valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (if0_out.valid !== 1'b0 || if0_in.ready !== 1'b1 || if0_out.data !== 48'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b data=%h, want valid=0 ready=1 data=0",
                     if0_out.valid, if0_in.ready, if0_out.data);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        if0_in.valid = 1'b1;
        if0_in.data  = {1'b0, 16'd1};
        @(negedge clk);
        if0_in.data  = {1'b1, 16'd2};
        @(negedge clk);
        if0_in.valid = 1'b0;
        checks++;
        if (if0_out.valid !== 1'b1 || if0_out.data !== {16'd2, 32'd3}) begin
            errors++;
            $display("FAIL reset_no_residue: valid=%b data=%h, want valid=1 data=%h",
                     if0_out.valid, if0_out.data, {16'd2, 32'd3});
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want;
`ifdef QACC_SAT_EN
        want = {8'd2, 8'd255};
`else
        want = {8'd2, 8'd44};
`endif
        if3_out.ready = 1'b1;
        @(negedge clk);
        if3_in.valid = 1'b1;
        if3_in.data  = {1'b0, 8'd200};
        @(negedge clk);
        if3_in.data  = {1'b1, 8'd100};
        @(negedge clk);
        if3_in.valid = 1'b0;
        checks++;
        if (if3_out.valid !== 1'b1 || if3_out.data !== want) begin
            errors++;
            $display("FAIL overflow_sum: valid=%b data=%h, want valid=1 data=%h",
                     if3_out.valid, if3_out.data, want);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        if0_in.valid = 1'b0; if0_in.data = '0; if0_out.ready = 1'b1;
        if1_in.valid = 1'b0; if1_in.data = '0; if1_out.ready = 1'b1;
        if2_in.valid = 1'b0; if2_in.data = '0; if2_out.ready = 1'b1;
        if3_in.valid = 1'b0; if3_in.data = '0; if3_out.ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_signed();
        test_stall();
        test_reset_midqueue();
        test_overflow();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
